// File: rtl/berger_protected_mem.sv
// Berger-coded memory: each word is stored as {data, zero_count(data)}, with a registered user
// read port, a background scrubber, error logging and an OR-mask fault-injection port.
module berger_protected_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8,
    localparam int CHK_W = $clog2(DATA_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       input_data,
    input  logic                    inj_en,
    input  logic [DATA_W+CHK_W-1:0] inj_mask,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       output_data,
    output logic                    rd_valid,
    output logic                    rd_error,
    input  logic                    scrub_en,
    output logic                    scrub_busy,
    output logic                    scrub_done,
    input  logic                    err_clear,
    output logic [CNT_W-1:0]        err_count,
    output logic [ADDR_W-1:0]       err_addr,
    output logic                    err_addr_valid
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = DATA_W + CHK_W;
    localparam logic [CW-1:0]    RST_WORD = {{DATA_W{1'b0}}, CHK_W'(DATA_W)};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    function automatic logic [CHK_W-1:0] f_zeros(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++)
            if (!d[i]) c = c + CHK_W'(1);
        return c;
    endfunction

    function automatic logic f_bad(input logic [CW-1:0] w);
        return f_zeros(w[CW-1:CHK_W]) != w[CHK_W-1:0];
    endfunction

    logic [CW-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_error;
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_sc_vld;
    logic [CW-1:0]     r_sc_word;
    logic [ADDR_W-1:0] r_sc_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_ea;
    logic              r_av;

    logic [CW-1:0]     w_rd_word;
    logic              w_u_err;
    logic              w_s_err;
    logic              w_busy;
    logic              w_done;
    logic              w_sc_rd;
    logic [1:0]        w_inc;
    logic [CNT_W-1:0]  w_cnt_base;
    logic [CNT_W:0]    w_sum;
    logic              w_av_base;

    // Storage: a write beats a coincident injection to the same port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_WORD;
        end else if (wr_en) begin
            r_mem[wr_addr] <= {input_data, f_zeros(input_data)};
        end else if (inj_en) begin
            r_mem[wr_addr] <= r_mem[wr_addr] | inj_mask;
        end
    end

    // Combinational array read sees pre-write contents, giving read-old behaviour
    assign w_rd_word = r_mem[rd_addr];
    assign w_u_err   = rd_en & f_bad(w_rd_word);
    assign w_s_err   = r_sc_vld & f_bad(r_sc_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_error <= w_u_err;
            if (rd_en) r_rd_data <= w_rd_word[CW-1:CHK_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (scrub_en) w_next = S_SCAN;
            S_SCAN: begin
                if (!scrub_en)
                    w_next = S_IDLE;
                else if (!rd_en && r_ptr == ADDR_W'(DEPTH - 1))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = scrub_en ? S_SCAN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_SCAN);
        w_done  = (r_state == S_DONE);
        w_sc_rd = w_busy & scrub_en & ~rd_en;
    end

    // Scrub read is captured here and checked one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_sc_vld  <= 1'b0;
            r_sc_word <= '0;
            r_sc_addr <= '0;
        end else begin
            r_sc_vld <= w_sc_rd;
            if (w_sc_rd) begin
                r_sc_word <= r_mem[r_ptr];
                r_sc_addr <= r_ptr;
                r_ptr     <= r_ptr + ADDR_W'(1);
            end else if (r_state != S_SCAN) begin
                r_ptr <= '0;
            end
        end
    end

    // Clear applies first, so errors maturing in the same cycle land on a fresh log
    always_comb begin
        w_inc      = {1'b0, w_u_err} + {1'b0, w_s_err};
        w_cnt_base = err_clear ? '0 : r_cnt;
        w_sum      = {1'b0, w_cnt_base} + (CNT_W + 1)'(w_inc);
        w_av_base  = ~err_clear & r_av;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ea  <= '0;
            r_av  <= 1'b0;
        end else begin
            r_cnt <= w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
            if (!w_av_base && (w_u_err || w_s_err)) begin
                r_av <= 1'b1;
                r_ea <= w_u_err ? rd_addr : r_sc_addr;
            end else begin
                r_av <= w_av_base;
            end
        end
    end

    assign output_data    = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign rd_error       = r_rd_error;
    assign scrub_busy     = w_busy;
    assign scrub_done     = w_done;
    assign err_count      = r_cnt;
    assign err_addr       = r_ea;
    assign err_addr_valid = r_av;

endmodule

// File: tb/tb_berger_protected_mem.sv
// Directed bench for berger_protected_mem: main 8-bit instance plus a CNT_W=2 instance for saturation.
module tb_berger_protected_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 0, inj_en = 0, rd_en = 0, scrub_en = 0, err_clear = 0;
    logic [3:0]  wr_addr = 0, rd_addr = 0;
    logic [7:0]  input_data = 0;
    logic [11:0] inj_mask = 0;
    logic [7:0]  output_data;
    logic        rd_valid, rd_error, scrub_busy, scrub_done, err_addr_valid;
    logic [7:0]  err_count;
    logic [3:0]  err_addr;

    logic        s_wr_en = 0, s_inj_en = 0, s_rd_en = 0, s_err_clear = 0;
    logic [3:0]  s_wr_addr = 0, s_rd_addr = 0;
    logic [11:0] s_inj_mask = 0;
    logic [7:0]  s_output_data;
    logic        s_rd_valid, s_rd_error, s_scrub_busy, s_scrub_done, s_err_addr_valid;
    logic [1:0]  s_err_count;
    logic [3:0]  s_err_addr;

    int n_chk = 0;
    int n_err = 0;
    int busy_n, done_n, rdv_n;

    always #5 clk = ~clk;

    berger_protected_mem #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .input_data(input_data),
        .inj_en(inj_en), .inj_mask(inj_mask), .rd_en(rd_en), .rd_addr(rd_addr),
        .output_data(output_data), .rd_valid(rd_valid), .rd_error(rd_error),
        .scrub_en(scrub_en), .scrub_busy(scrub_busy), .scrub_done(scrub_done),
        .err_clear(err_clear), .err_count(err_count), .err_addr(err_addr),
        .err_addr_valid(err_addr_valid)
    );

    berger_protected_mem #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .input_data(8'h00),
        .inj_en(s_inj_en), .inj_mask(s_inj_mask), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .output_data(s_output_data), .rd_valid(s_rd_valid), .rd_error(s_rd_error),
        .scrub_en(1'b0), .scrub_busy(s_scrub_busy), .scrub_done(s_scrub_done),
        .err_clear(s_err_clear), .err_count(s_err_count), .err_addr(s_err_addr),
        .err_addr_valid(s_err_addr_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".data"},  output_data, 0);
        chk({tag, ".rdv"},   rd_valid, 0);
        chk({tag, ".rderr"}, rd_error, 0);
        chk({tag, ".busy"},  scrub_busy, 0);
        chk({tag, ".done"},  scrub_done, 0);
        chk({tag, ".cnt"},   err_count, 0);
        chk({tag, ".eaddr"}, err_addr, 0);
        chk({tag, ".eav"},   err_addr_valid, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; input_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic inj(input logic [3:0] a, input logic [11:0] m);
        inj_en = 1; wr_addr = a; inj_mask = m;
        tick();
        inj_en = 0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1; rd_addr = a;
        tick();
        rd_en = 0;
    endtask

    initial begin
        tick(); tick();
        chk_all_zero("reset");
        rst = 0;
        tick();

        // Reset contents: {0, 8} is a valid codeword
        rd(4'd5);
        chk("rd5.valid", rd_valid, 1);
        chk("rd5.data", output_data, 8'h00);
        chk("rd5.err", rd_error, 0);
        chk("rd5.cnt", err_count, 0);
        tick();
        chk("rd5.pulse", rd_valid, 0);
        chk("rd5.hold", output_data, 8'h00);

        wr(4'd3, 8'hA5);
        rd(4'd3);
        chk("rdA5.data", output_data, 8'hA5);
        chk("rdA5.err", rd_error, 0);

        // Same-cycle write and read: old data returned
        wr_en = 1; wr_addr = 4'd3; input_data = 8'h3C; rd_en = 1; rd_addr = 4'd3;
        tick();
        wr_en = 0; rd_en = 0;
        chk("rdold.data", output_data, 8'hA5);
        rd(4'd3);
        chk("rdnew.data", output_data, 8'h3C);

        // Write and injection together: write wins
        wr_en = 1; inj_en = 1; wr_addr = 4'd7; input_data = 8'h0F; inj_mask = 12'hFFF;
        tick();
        wr_en = 0; inj_en = 0;
        rd(4'd7);
        chk("wrwins.data", output_data, 8'h0F);
        chk("wrwins.err", rd_error, 0);

        // Data bit1 0->1: 0xA7 has 3 zeros, check still 4
        wr(4'd3, 8'hA5);
        inj(4'd3, 12'h020);
        rd(4'd3);
        chk("inj.data", output_data, 8'hA7);
        chk("inj.err", rd_error, 1);
        chk("inj.cnt", err_count, 1);
        chk("inj.eaddr", err_addr, 3);
        chk("inj.eav", err_addr_valid, 1);

        err_clear = 1; tick(); err_clear = 0;
        chk("clr.cnt", err_count, 0);
        chk("clr.eav", err_addr_valid, 0);
        wr(4'd3, 8'hA5);

        // Corrupt @2 (check bit) and @9 (data bit7), then scrub with no user traffic
        inj(4'd2, 12'h001);
        inj(4'd9, 12'h800);
        busy_n = 0; done_n = 0; rdv_n = 0;
        scrub_en = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            busy_n += int'(scrub_busy);
            done_n += int'(scrub_done);
            rdv_n  += int'(rd_valid);
            if (scrub_done) scrub_en = 0;
        end
        chk("scrub1.busy", busy_n, 16);
        chk("scrub1.done", done_n, 1);
        chk("scrub1.rdv", rdv_n, 0);
        chk("scrub1.cnt", err_count, 2);
        chk("scrub1.eaddr", err_addr, 2);
        chk("scrub1.eav", err_addr_valid, 1);

        // Scrub with a user read stalling every other cycle
        err_clear = 1; tick(); err_clear = 0;
        busy_n = 0; done_n = 0;
        scrub_en = 1; rd_addr = 4'd0;
        for (int k = 1; k <= 80; k++) begin
            rd_en = (k % 2 == 0) && (done_n == 0);
            tick();
            busy_n += int'(scrub_busy);
            done_n += int'(scrub_done);
            if (scrub_done) scrub_en = 0;
        end
        rd_en = 0;
        chk("scrub2.busy", busy_n, 32);
        chk("scrub2.done", done_n, 1);
        chk("scrub2.cnt", err_count, 2);
        chk("scrub2.eaddr", err_addr, 2);

        // Abort mid-pass: back to IDLE, no done pulse
        err_clear = 1; tick(); err_clear = 0;
        done_n = 0;
        scrub_en = 1;
        for (int k = 0; k < 6; k++) tick();
        chk("abort.busy_mid", scrub_busy, 1);
        scrub_en = 0;
        tick();
        chk("abort.busy", scrub_busy, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            done_n += int'(scrub_done);
        end
        chk("abort.done", done_n, 0);
        chk("abort.cnt", err_count, 1);

        // Reset in the middle of a scan
        rd(4'd3);
        scrub_en = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("prerst.busy", scrub_busy, 1);
        rst = 1;
        #1;
        chk_all_zero("midrst");
        scrub_en = 0;
        tick();
        rst = 0;
        tick();
        rd(4'd2);
        chk("postrst.data", output_data, 8'h00);
        chk("postrst.err", rd_error, 0);

        // Saturating counter on the CNT_W=2 instance
        s_inj_en = 1; s_wr_addr = 4'd1; s_inj_mask = 12'h001;
        tick();
        s_inj_en = 0;
        s_rd_addr = 4'd1;
        for (int k = 1; k <= 4; k++) begin
            s_rd_en = 1; tick(); s_rd_en = 0;
            chk("sat.err", s_rd_error, 1);
            chk("sat.cnt", s_err_count, (k < 3) ? k : 3);
        end
        s_rd_en = 1; s_err_clear = 1;
        tick();
        s_rd_en = 0; s_err_clear = 0;
        chk("clrerr.cnt", s_err_count, 1);
        chk("clrerr.eav", s_err_addr_valid, 1);
        chk("clrerr.eaddr", s_err_addr, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
